// File: rtl/period2note.sv
// Half-period meter for a square wave that maps the measured period back to a MIDI note number.
// Optional P2N_CONFIRM_EN: publish a successful note only when two consecutive conversions agree.
module period2note #(
    parameter int unsigned CNT_BW = 16
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       sig_i,
    output logic [7:0] note_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       busy_o
);

    localparam logic [2:0] StWaitFirst = 3'd0;
    localparam logic [2:0] StArmed     = 3'd1;
    localparam logic [2:0] StNorm      = 3'd2;
    localparam logic [2:0] StSearch    = 3'd3;
    localparam logic [2:0] StDone      = 3'd4;

    logic              sync1_q, sync2_q, edge_q;
    logic              sig_edge;
    logic [CNT_BW-1:0] cnt_q;
    logic              cnt_sat;

    logic [2:0]        state_q, state_d;
    logic [CNT_BW-1:0] per_q, per_d;
    logic [7:0]        v_q, v_d;
    logic [3:0]        s_q, s_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        best_idx_q, best_idx_d;
    logic [7:0]        best_diff_q, best_diff_d;
    logic [7:0]        note_q, note_d;
    logic              err_q, err_d;
    logic              to_wait_q, to_wait_d;
`ifdef P2N_CONFIRM_EN
    logic [7:0]        cand_q, cand_d;
`endif

    logic [7:0] msb;
    logic [7:0] shift;
    logic       range_err;
    logic [7:0] v_next;
    logic [7:0] rom_val;
    logic [7:0] diff;
    logic       better;
    logic [3:0] fin_idx;
    logic [7:0] octave;
    logic [7:0] note_calc;

    function automatic logic [7:0] rom(input logic [3:0] i);
        case (i)
            4'd0:    rom = 8'd248;
            4'd1:    rom = 8'd234;
            4'd2:    rom = 8'd221;
            4'd3:    rom = 8'd209;
            4'd4:    rom = 8'd197;
            4'd5:    rom = 8'd186;
            4'd6:    rom = 8'd175;
            4'd7:    rom = 8'd165;
            4'd8:    rom = 8'd156;
            4'd9:    rom = 8'd147;
            4'd10:   rom = 8'd139;
            default: rom = 8'd131;
        endcase
    endfunction

    // Both polarities count: the measured interval is a half-period.
    assign sig_edge = sync2_q ^ edge_q;
    assign cnt_sat  = &cnt_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            if (sig_edge) begin
                cnt_q <= CNT_BW'(1);
            end else if (!cnt_sat) begin
                cnt_q <= cnt_q + CNT_BW'(1);
            end
        end
    end

    always_comb begin
        msb = '0;
        for (int unsigned i = 0; i < CNT_BW; i++) begin
            if (per_q[i]) msb = 8'(i);
        end
    end

    // Normalise the period into the base-octave range 128..255.
    assign range_err = (msb < 8'd7) || (msb > 8'd15);
    assign shift     = msb - 8'd7;
    assign v_next    = 8'(per_q >> shift);

    assign rom_val   = rom(idx_q);
    assign diff      = (v_q >= rom_val) ? (v_q - rom_val) : (rom_val - v_q);
    assign better    = (idx_q == 4'd0) || (diff < best_diff_q);
    assign fin_idx   = better ? idx_q : best_idx_q;
    assign octave    = 8'd8 - {4'd0, s_q};
    assign note_calc = 8'd21 + octave * 8'd12 + {4'd0, fin_idx};

    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        v_d         = v_q;
        s_d         = s_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_diff_d = best_diff_q;
        note_d      = note_q;
        err_d       = err_q;
        to_wait_d   = to_wait_q;
`ifdef P2N_CONFIRM_EN
        cand_d      = cand_q;
`endif
        case (state_q)
            StWaitFirst: begin
                if (sig_edge) state_d = StArmed;
            end
            StArmed: begin
                if (sig_edge) begin
                    per_d   = cnt_q;
                    state_d = StNorm;
                end else if (cnt_sat) begin
                    err_d     = 1'b1;
                    to_wait_d = 1'b1;
`ifdef P2N_CONFIRM_EN
                    cand_d    = '0;
`endif
                    state_d   = StDone;
                end
            end
            StNorm: begin
                to_wait_d = 1'b0;
                if (range_err) begin
                    err_d   = 1'b1;
`ifdef P2N_CONFIRM_EN
                    cand_d  = '0;
`endif
                    state_d = StDone;
                end else begin
                    v_d     = v_next;
                    s_d     = shift[3:0];
                    idx_d   = 4'd0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (better) begin
                    best_idx_d  = idx_q;
                    best_diff_d = diff;
                end
                if (idx_q == 4'd11) begin
`ifdef P2N_CONFIRM_EN
                    cand_d = note_calc;
                    if (note_calc == cand_q) begin
                        note_d  = note_calc;
                        err_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        state_d = StArmed;
                    end
`else
                    note_d  = note_calc;
                    err_d   = 1'b0;
                    state_d = StDone;
`endif
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                state_d = to_wait_q ? StWaitFirst : StArmed;
            end
            default: state_d = StWaitFirst;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= StWaitFirst;
            per_q       <= '0;
            v_q         <= '0;
            s_q         <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_diff_q <= '0;
            note_q      <= '0;
            err_q       <= 1'b0;
            to_wait_q   <= 1'b0;
`ifdef P2N_CONFIRM_EN
            cand_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            v_q         <= v_d;
            s_q         <= s_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_diff_q <= best_diff_d;
            note_q      <= note_d;
            err_q       <= err_d;
            to_wait_q   <= to_wait_d;
`ifdef P2N_CONFIRM_EN
            cand_q      <= cand_d;
`endif
        end
    end

    assign note_o  = note_q;
    assign err_o   = err_q;
    assign valid_o = (state_q == StDone);
    assign busy_o  = (state_q == StNorm) || (state_q == StSearch);

endmodule

// File: tb/tb_period2note.sv
// Directed bench for period2note: square waves of known half-period, range errors, timeout,
// and reset abort, each checked against hand-computed note/err/latency values.
module tb_period2note;

    logic       clk_i = 1'b0;
    logic       nrst_i = 1'b0;
    logic       sig_i = 1'b0;
    logic [7:0] note_o;
    logic       valid_o;
    logic       err_o;
    logic       busy_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_tog = 0;

    period2note #(.CNT_BW(16)) dut (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .sig_i   (sig_i),
        .note_o  (note_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic toggle();
        sig_i = ~sig_i;
        last_tog = cyc;
    endtask

    // Latch an edge h cycles after the previous one, then time the valid pulse.
    // exp_lat == 0 means no valid_o is expected within the window.
    task automatic meas(input string tag, input int h, input bit pre, input int exp_note,
                        input int exp_err, input int exp_lat);
        int lat;
        int busy3;
        if (pre) toggle();
        while (cyc - last_tog < h) tick();
        toggle();
        lat = 0;
        busy3 = 0;
        while (!valid_o && lat < 40) begin
            tick();
            lat++;
            if (lat == 3) busy3 = int'(busy_o);
        end
        check({tag, "_lat"}, valid_o ? lat : 0, exp_lat);
        if (exp_lat != 0) begin
            check({tag, "_note"}, int'(note_o), exp_note);
            check({tag, "_err"}, int'(err_o), exp_err);
            check({tag, "_busy"}, busy3, 1);
            tick();
            check({tag, "_pulse"}, int'(valid_o), 0);
        end
    endtask

    initial begin
        int nval;
        #2;
        check("rst_note", int'(note_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_busy", int'(busy_o), 0);
        tick();
        nrst_i = 1'b1;
        repeat (3) tick();

        meas("h3968", 3968, 1'b1, 69, 0, 16);
        meas("h6688", 6688, 1'b1, 60, 0, 16);
        meas("h248", 248, 1'b1, 117, 0, 16);
        meas("h131", 131, 1'b1, 128, 0, 16);
        meas("h250", 250, 1'b1, 117, 0, 16);
        meas("h129", 129, 1'b1, 128, 0, 16);
        meas("h100", 100, 1'b1, 128, 1, 4);

        // No further edges: counter saturates 65535 cycles after the last restart.
        while (!valid_o && (cyc - last_tog) < 70000) tick();
        check("tmo_cyc", cyc - last_tog, 65538);
        check("tmo_err", int'(err_o), 1);
        check("tmo_note", int'(note_o), 128);
        tick();
        meas("tmo_rec", 3968, 1'b1, 69, 0, 16);

        toggle();
        while (cyc - last_tog < 248) tick();
        toggle();
        repeat (8) tick();
        check("mid_busy", int'(busy_o), 1);
        #2;
        nrst_i = 1'b0;
        sig_i = 1'b0;
        #1;
        check("abort_note", int'(note_o), 0);
        check("abort_valid", int'(valid_o), 0);
        check("abort_err", int'(err_o), 0);
        check("abort_busy", int'(busy_o), 0);
        tick();
        nrst_i = 1'b1;
        nval = 0;
        repeat (30) begin
            tick();
            if (valid_o) nval++;
        end
        check("abort_novalid", nval, 0);

`ifdef P2N_CONFIRM_EN
        meas("cf_first", 248, 1'b1, 0, 0, 0);
        meas("cf_second", 248, 1'b0, 117, 0, 16);
`else
        meas("post_rst", 248, 1'b1, 117, 0, 16);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
